// File: rtl/card_ram_arbiter_if.sv
// Bus bundle between the card-data RAM arbiter and the rest of the game logic:
// requester side (mode, req/addr, gnt/rvalid/rdata/busy) plus the RAM port.
interface card_ram_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic [2:0]        mode;
    logic [2:0]        req;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic [2:0]        gnt;
    logic [2:0]        rvalid;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    // Arbiter side
    modport slave (
        input  mode, req, addr0, addr1, addr2, ram_rdata,
        output gnt, rvalid, rdata, busy, ram_en, ram_addr
    );

    // Requesters and RAM side
    modport master (
        output mode, req, addr0, addr1, addr2, ram_rdata,
        input  gnt, rvalid, rdata, busy, ram_en, ram_addr
    );
endinterface

// File: rtl/card_ram_arbiter.sv
// Round-robin arbiter sharing one card-data RAM among decode (0), buy (1) and
// draw/shuffle (2). Each access runs IDLE -> ISSUE -> WAIT(RD_LAT) -> DONE and
// returns registered data with a one-cycle per-requester valid pulse. A change
// of game phase throws away any in-flight access and restarts priority at 0.
module card_ram_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic               clk,
    input  logic               reset,
    card_ram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [1:0]        win_q, win_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [2:0]        mode_q;
    logic              mode_chg;
    logic [1:0]        pick;

    // Search req upward from ptr with wrap 2 -> 0; first set bit wins.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] ptr);
        int         s;
        logic [1:0] idx;
        rr_pick = ptr;
        for (int i = 2; i >= 0; i--) begin
            s = int'(ptr) + i;
            if (s >= 3) s = s - 3;
            idx = s[1:0];
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    assign mode_chg = (bus.mode != mode_q);
    assign pick     = rr_pick(bus.req, ptr_q);

    // Next-state and datapath next values; a phase change overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        if (mode_chg) begin
            state_d = IDLE;
            ptr_d   = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req != 3'b000) begin
                        win_d   = pick;
                        case (pick)
                            2'd1:    addr_d = bus.addr1;
                            2'd2:    addr_d = bus.addr2;
                            default: addr_d = bus.addr0;
                        endcase
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_d   = 3'(RD_LAT);
                    state_d = WAIT;
                end
                WAIT: begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        rdata_d = bus.ram_rdata;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    ptr_d   = (win_q == 2'd2) ? 2'd0 : win_q + 2'd1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, pointer, latched request and read-data registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            win_q   <= 2'd0;
            ptr_q   <= 2'd0;
            addr_q  <= '0;
            rdata_q <= '0;
            mode_q  <= bus.mode;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            mode_q  <= bus.mode;
        end
    end

    // Outputs decode straight from state so async reset clears them at once.
    assign bus.busy     = (state_q != IDLE);
    assign bus.ram_en   = (state_q == ISSUE);
    assign bus.ram_addr = (state_q == ISSUE) ? addr_q : '0;
    assign bus.gnt      = (state_q == ISSUE) ? (3'b001 << win_q) : 3'b000;
    assign bus.rvalid   = (state_q == DONE)  ? (3'b001 << win_q) : 3'b000;
    assign bus.rdata    = rdata_q;

endmodule

// File: tb/tb_card_ram_arbiter.sv
// Bench for card_ram_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_card_ram_arbiter;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 2;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   cyc;

    card_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    card_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // RAM model: data for an enabled address appears RD_LAT cycles later,
    // junk otherwise so a mistimed capture is visible.
    logic [DATA_W-1:0] mem [16];
    logic              sr_en   [RD_LAT];
    logic [ADDR_W-1:0] sr_addr [RD_LAT];
    logic [DATA_W-1:0] junk;

    always @(posedge clk) begin
        sr_en[0]   <= bus.ram_en;
        sr_addr[0] <= bus.ram_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            sr_en[i]   <= sr_en[i-1];
            sr_addr[i] <= sr_addr[i-1];
        end
        junk <= 16'($urandom);
    end

    assign bus.ram_rdata = sr_en[RD_LAT-1] ? mem[sr_addr[RD_LAT-1]] : junk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: an access is a numbered sequence of cycles k=1..RD_LAT+2
    // following the arbitration cycle (1 = issue, RD_LAT+2 = data returned).
    bit                m_active;
    int                m_k;
    int                m_win;
    int                m_ptr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_rdata;
    logic [2:0]        m_mode;

    initial begin
        logic [2:0] e_gnt;
        logic [2:0] e_rvalid;
        int         idx;
        m_active = 0; m_k = 0; m_win = 0; m_ptr = 0; m_addr = '0; m_rdata = '0; m_mode = 3'd0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_active = 0;
                m_ptr    = 0;
                m_rdata  = '0;
                m_mode   = bus.mode;
            end
            e_gnt    = (m_active && m_k == 1)          ? 3'(1 << m_win) : 3'b000;
            e_rvalid = (m_active && m_k == RD_LAT + 2) ? 3'(1 << m_win) : 3'b000;
            check("gnt",    bus.gnt,    e_gnt);
            check("rvalid", bus.rvalid, e_rvalid);
            check("busy",   bus.busy,   m_active);
            check("ram_en", bus.ram_en, (m_active && m_k == 1));
            check("rdata",  bus.rdata,  m_rdata);
            if (m_active && m_k == 1) check("ram_addr", bus.ram_addr, m_addr);
            if (reset) begin
                if (bus.mode != m_mode) begin
                    m_mode   = bus.mode;
                    m_active = 0;
                    m_ptr    = 0;
                end else if (m_active) begin
                    if (m_k == RD_LAT + 1) m_rdata = mem[m_addr];
                    if (m_k == RD_LAT + 2) begin
                        m_active = 0;
                        m_ptr    = (m_win + 1) % 3;
                    end else begin
                        m_k++;
                    end
                end else if (bus.req != 3'b000) begin
                    for (int i = 2; i >= 0; i--) begin
                        idx = (m_ptr + i) % 3;
                        if (bus.req[idx]) m_win = idx;
                    end
                    m_addr   = (m_win == 0) ? bus.addr0 : (m_win == 1) ? bus.addr1 : bus.addr2;
                    m_active = 1;
                    m_k      = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int max);
        int n = 0;
        while (bus.gnt == 3'b000 && n < max) begin
            tick();
            n++;
        end
        check("gnt_timeout", (bus.gnt != 3'b000), 1);
    endtask

    task automatic wait_rvalid(input int max);
        int n = 0;
        while (bus.rvalid == 3'b000 && n < max) begin
            tick();
            n++;
        end
        check("rvalid_timeout", (bus.rvalid != 3'b000), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int         prev;
        logic [2:0] exp_g;
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        bus.mode = 3'd4;
        bus.req  = 3'b000;
        bus.addr0 = '0; bus.addr1 = '0; bus.addr2 = '0;
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        mem[5] = 16'hBEEF;
        mem[1] = 16'h1111; mem[2] = 16'h2222; mem[3] = 16'h3333;
        mem[7] = 16'h7777; mem[9] = 16'h9999;
        #2;
        check("reset_gnt",   bus.gnt,    0);
        check("reset_busy",  bus.busy,   0);
        check("reset_rdata", bus.rdata,  0);
        tick(); tick(); tick();
        reset = 1'b1;
        tick();

        // Single read
        bus.req = 3'b001; bus.addr0 = 4'h5;
        tick();
        check("t1_gnt", bus.gnt, 3'b001);
        check("t1_ram_en", bus.ram_en, 1);
        check("t1_ram_addr", bus.ram_addr, 4'h5);
        tick(); tick(); tick();
        check("t1_rvalid", bus.rvalid, 3'b001);
        check("t1_rdata", bus.rdata, 16'hBEEF);
        bus.req = 3'b000;
        tick();
        check("t1_busy_low", bus.busy, 0);

        // Rotated pointer: requester 1 first, then 0
        bus.req = 3'b011; bus.addr0 = 4'h1; bus.addr1 = 4'h2;
        wait_gnt(20);
        check("t3_first", bus.gnt, 3'b010);
        tick();
        wait_gnt(20);
        check("t3_second", bus.gnt, 3'b001);
        wait_rvalid(20);
        bus.req = 3'b000;
        tick(); tick();

        // Mode abort in the first WAIT cycle
        bus.req = 3'b010;
        tick();
        check("t4_gnt", bus.gnt, 3'b010);
        tick();
        bus.mode = 3'd5; bus.req = 3'b011;
        tick();
        check("t4_idle", bus.busy, 0);
        wait_gnt(20);
        check("t4_ptr0", bus.gnt, 3'b001);
        wait_rvalid(20);
        bus.req = 3'b010;
        tick();
        wait_rvalid(20);
        bus.req = 3'b000;
        tick();

        // Phase change while idle resets priority, then round robin
        bus.mode = 3'd4;
        tick(); tick();
        bus.req = 3'b111; bus.addr0 = 4'h1; bus.addr1 = 4'h2; bus.addr2 = 4'h3;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(20);
            exp_g = 3'(1 << (i % 3));
            check("rr_gnt", bus.gnt, exp_g);
            if (i > 0) check("rr_spacing", cyc - prev, RD_LAT + 3);
            prev = cyc;
            if (i == 3) bus.req = 3'b000;
            wait_rvalid(20);
            check("rr_rdata", bus.rdata, mem[(i % 3) + 1]);
            tick();
        end
        tick(); tick();

        // Requester 2 drops req and changes addr mid-access
        bus.req = 3'b100; bus.addr2 = 4'h7;
        wait_gnt(20);
        check("t5_gnt", bus.gnt, 3'b100);
        tick();
        bus.req = 3'b000; bus.addr2 = 4'h9;
        wait_rvalid(20);
        check("t5_rvalid", bus.rvalid, 3'b100);
        check("t5_rdata", bus.rdata, 16'h7777);
        tick(); tick();

        // Asynchronous reset during ISSUE
        bus.req = 3'b001; bus.addr0 = 4'h3;
        wait_gnt(20);
        #2;
        reset = 1'b0;
        #1;
        check("ar_ram_en", bus.ram_en, 0);
        check("ar_gnt", bus.gnt, 0);
        check("ar_rvalid", bus.rvalid, 0);
        check("ar_busy", bus.busy, 0);
        bus.req = 3'b110;
        tick(); tick();
        reset = 1'b1;
        check("ar_rdata", bus.rdata, 0);
        wait_gnt(20);
        check("ar_first", bus.gnt, 3'b010);
        bus.req = 3'b000;
        tick();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] r;
            r = bus.req;
            for (int b = 0; b < 3; b++) begin
                int x;
                x = int'($urandom_range(0, 9));
                r[b] = r[b] ? (x != 0) : (x < 3);
            end
            bus.req   = r;
            bus.addr0 = 4'($urandom);
            bus.addr1 = 4'($urandom);
            bus.addr2 = 4'($urandom);
            if ($urandom_range(0, 39) == 0) bus.mode = 3'($urandom_range(1, 6));
            tick();
        end
        bus.req = 3'b000;
        for (int n = 0; n < 20; n++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
